// File: rtl/ibex_branch_predict_bht_if.sv
// Fetch, training and prediction signals of the BHT branch predictor.
interface ibex_branch_predict_bht_if;
    logic [31:0] fetch_rdata_i;
    logic [31:0] fetch_pc_i;
    logic        fetch_valid_i;
    logic        bht_en_i;
    logic        flush_i;
    logic        update_valid_i;
    logic [31:0] update_pc_i;
    logic        update_taken_i;
    logic        predict_branch_taken_o;
    logic [31:0] predict_branch_pc_o;
    logic        predict_from_bht_o;

    // Fetch/ID side driving the predictor
    modport master (
        output fetch_rdata_i, fetch_pc_i, fetch_valid_i, bht_en_i, flush_i,
        output update_valid_i, update_pc_i, update_taken_i,
        input  predict_branch_taken_o, predict_branch_pc_o, predict_from_bht_o
    );

    // Predictor side
    modport slave (
        input  fetch_rdata_i, fetch_pc_i, fetch_valid_i, bht_en_i, flush_i,
        input  update_valid_i, update_pc_i, update_taken_i,
        output predict_branch_taken_o, predict_branch_pc_o, predict_from_bht_o
    );
endinterface

// File: rtl/ibex_branch_predict_bht.sv
// Fetch-stage branch predictor: static decode of the target plus a direct-mapped
// table of saturating counters giving the direction of trained conditional branches.
module ibex_branch_predict_bht #(
    parameter int unsigned BhtEntries   = 64,
    parameter int unsigned CounterWidth = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    ibex_branch_predict_bht_if.slave bus
);
    localparam int unsigned IdxW = $clog2(BhtEntries);

    localparam logic [6:0] OpcBranch = 7'h63;
    localparam logic [6:0] OpcJal    = 7'h6f;

    // Weakly-taken / weakly-not-taken seeds for a freshly trained entry
    localparam logic [CounterWidth-1:0] CntWt  = CounterWidth'(1) << (CounterWidth - 1);
    localparam logic [CounterWidth-1:0] CntWn  = CntWt - CounterWidth'(1);
    localparam logic [CounterWidth-1:0] CntMax = '1;

    logic [BhtEntries-1:0]   v_q, v_d;
    logic [CounterWidth-1:0] c_q [BhtEntries];
    logic [CounterWidth-1:0] c_d [BhtEntries];

    logic [31:0]             instr;
    logic                    is_b, is_j, is_cb, is_cj;
    logic [31:0]             imm_b, imm_j, imm_cb, imm_cj, imm;
    logic [IdxW-1:0]         rd_idx, wr_idx;
    logic [CounterWidth-1:0] rd_cnt, wr_cnt;
    logic                    pred_taken, pred_from_bht;
    logic                    unused_update_pc;

    assign instr  = bus.fetch_rdata_i;
    assign rd_idx = bus.fetch_pc_i[IdxW:1];
    assign wr_idx = bus.update_pc_i[IdxW:1];
    assign rd_cnt = c_q[rd_idx];
    assign wr_cnt = c_q[wr_idx];

    // Only the index bits of the update PC matter; the table is untagged
    assign unused_update_pc = ^{bus.update_pc_i[31:IdxW+1], bus.update_pc_i[0]};

    // Immediates of the four control-transfer formats, sign-extended
    assign imm_b  = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_j  = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_cb = {{24{instr[12]}}, instr[6:5], instr[2], instr[11:10], instr[4:3], 1'b0};
    assign imm_cj = {{21{instr[12]}}, instr[8], instr[10:9], instr[6], instr[7], instr[2],
                     instr[11], instr[5:3], 1'b0};

    // Instruction-type decode and immediate select (B-type by default)
    always_comb begin
        is_b  = (instr[6:0] == OpcBranch);
        is_j  = (instr[6:0] == OpcJal);
        is_cj = (instr[1:0] == 2'b01) && (instr[14:13] == 2'b01);
        is_cb = (instr[1:0] == 2'b01) && (instr[15:14] == 2'b11);
        imm   = imm_b;
        if (is_j) begin
            imm = imm_j;
        end else if (is_cj) begin
            imm = imm_cj;
        end else if (is_cb) begin
            imm = imm_cb;
        end
    end

    // Direction: jumps always taken, trained branches from the counter MSB, else BTFN
    always_comb begin
        pred_taken    = 1'b0;
        pred_from_bht = 1'b0;
        if (bus.fetch_valid_i) begin
            if (is_j || is_cj) begin
                pred_taken = 1'b1;
            end else if (is_b || is_cb) begin
                if (bus.bht_en_i && v_q[rd_idx]) begin
                    pred_taken    = rd_cnt[CounterWidth-1];
                    pred_from_bht = 1'b1;
                end else begin
                    pred_taken = imm[31];
                end
            end
        end
    end

    assign bus.predict_branch_taken_o = pred_taken;
    assign bus.predict_from_bht_o     = pred_from_bht;
    assign bus.predict_branch_pc_o    = bus.fetch_pc_i + imm;

    // Table next state: flush drops validity (and any same-cycle update), else train one entry
    always_comb begin
        v_d = v_q;
        c_d = c_q;
        if (bus.flush_i) begin
            v_d = '0;
        end else if (bus.update_valid_i) begin
            if (!v_q[wr_idx]) begin
                v_d[wr_idx] = 1'b1;
                c_d[wr_idx] = bus.update_taken_i ? CntWt : CntWn;
            end else if (bus.update_taken_i) begin
                if (wr_cnt != CntMax) begin
                    c_d[wr_idx] = wr_cnt + CounterWidth'(1);
                end
            end else begin
                if (wr_cnt != '0) begin
                    c_d[wr_idx] = wr_cnt - CounterWidth'(1);
                end
            end
        end
    end

    // Table registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            v_q <= '0;
            for (int i = 0; i < int'(BhtEntries); i++) begin
                c_q[i] <= '0;
            end
        end else begin
            v_q <= v_d;
            c_q <= c_d;
        end
    end

    // Decoded instruction types never overlap
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.fetch_valid_i |-> $onehot0({is_b, is_j, is_cb, is_cj}))
        else $error("instruction type decode not one-hot0");

endmodule

// File: tb/tb_ibex_branch_predict_bht.sv
// Scoreboard bench for the BHT branch predictor (BhtEntries=64, CounterWidth=2).
module tb_ibex_branch_predict_bht;
    typedef struct packed {
        logic        taken;
        logic        bht;
        logic [31:0] pc;
    } res_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    res_t  exp_q[$];
    string name_q[$];

    ibex_branch_predict_bht_if bus ();

    ibex_branch_predict_bht #(
        .BhtEntries  (64),
        .CounterWidth(2)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    function automatic res_t observed();
        res_t r;
        r.taken = bus.predict_branch_taken_o;
        r.bht   = bus.predict_from_bht_o;
        r.pc    = bus.predict_branch_pc_o;
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one fetch and record the expected prediction
    task automatic drive_fetch(input string nm, input logic [31:0] rdata, input logic [31:0] pc,
                               input logic valid, input logic taken, input logic bht,
                               input logic [31:0] tgt);
        res_t e;
        bus.fetch_rdata_i = rdata;
        bus.fetch_pc_i    = pc;
        bus.fetch_valid_i = valid;
        e.taken = taken;
        e.bht   = bht;
        e.pc    = tgt;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic do_update(input logic [31:0] pc, input logic taken);
        bus.update_valid_i = 1'b1;
        bus.update_pc_i    = pc;
        bus.update_taken_i = taken;
        cyc();
        bus.update_valid_i = 1'b0;
        bus.update_pc_i    = 32'hdead_beef;
    endtask

    task automatic pulse_reset();
        rst_n              = 1'b0;
        bus.flush_i        = 1'b1;
        bus.update_valid_i = 1'b1;
        bus.update_pc_i    = 32'h100;
        bus.update_taken_i = 1'b1;
        cyc();
        cyc();
        rst_n              = 1'b1;
        bus.flush_i        = 1'b0;
        bus.update_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        res_t e, g; string nm;
        drive_fetch("reset_invalid_fetch", 32'h0000_0863, 32'h100, 1'b0, 1'b0, 1'b0, 32'h110);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        cyc();
        rst_n = 1'b1;
        cyc();
        drive_fetch("reset_untrained_backward", 32'hFE00_0EE3, 32'h100, 1'b1, 1'b1, 1'b0, 32'hFC);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
    endtask

    task automatic test_static();
        res_t e, g; string nm;
        cyc();
        drive_fetch("static_forward", 32'h0000_0863, 32'h100, 1'b1, 1'b0, 1'b0, 32'h110);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        cyc();
        drive_fetch("non_branch_addi", 32'h0000_0013, 32'h104, 1'b1, 1'b0, 1'b0, 32'h104);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
    endtask

    task automatic test_training();
        res_t e, g; string nm;
        do_update(32'h100, 1'b1);
        drive_fetch("train_taken_wt", 32'h0000_0863, 32'h100, 1'b1, 1'b1, 1'b1, 32'h110);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        do_update(32'h100, 1'b0);
        drive_fetch("train_wt_to_wn", 32'h0000_0863, 32'h100, 1'b1, 1'b0, 1'b1, 32'h110);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        cyc();
        bus.bht_en_i = 1'b0;
        drive_fetch("bht_disabled_backward", 32'hFE00_0EE3, 32'h100, 1'b1, 1'b1, 1'b0, 32'hFC);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        cyc();
        bus.bht_en_i = 1'b1;
    endtask

    task automatic test_saturation();
        res_t e, g; string nm;
        pulse_reset();
        for (int i = 0; i < 3; i++) do_update(32'h100, 1'b1);
        drive_fetch("sat_max_taken", 32'h0000_0863, 32'h100, 1'b1, 1'b1, 1'b1, 32'h110);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        do_update(32'h100, 1'b0);
        drive_fetch("sat_3_to_2", 32'h0000_0863, 32'h100, 1'b1, 1'b1, 1'b1, 32'h110);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        for (int i = 0; i < 4; i++) do_update(32'h100, 1'b0);
        drive_fetch("sat_min_reached", 32'hFE00_0EE3, 32'h100, 1'b1, 1'b0, 1'b1, 32'hFC);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        do_update(32'h100, 1'b0);
        drive_fetch("sat_min_hold", 32'hFE00_0EE3, 32'h100, 1'b1, 1'b0, 1'b1, 32'hFC);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
    endtask

    task automatic test_alias_same_cycle();
        res_t e, g; string nm;
        pulse_reset();
        do_update(32'h100, 1'b1);
        drive_fetch("alias_0x180", 32'h0000_0863, 32'h180, 1'b1, 1'b1, 1'b1, 32'h190);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        // Untrained index 2: update and fetch collide in the same cycle
        cyc();
        bus.update_valid_i = 1'b1;
        bus.update_pc_i    = 32'h104;
        bus.update_taken_i = 1'b1;
        drive_fetch("same_cycle_static", 32'h0000_0863, 32'h104, 1'b1, 1'b0, 1'b0, 32'h114);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        cyc();
        bus.update_valid_i = 1'b0;
        drive_fetch("same_cycle_next_bht", 32'h0000_0863, 32'h104, 1'b1, 1'b1, 1'b1, 32'h114);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
    endtask

    task automatic test_flush();
        res_t e, g; string nm;
        pulse_reset();
        do_update(32'h100, 1'b0);
        drive_fetch("flush_pre_trained_nt", 32'hFE00_0EE3, 32'h100, 1'b1, 1'b0, 1'b1, 32'hFC);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        bus.flush_i = 1'b1;
        do_update(32'h100, 1'b0);
        bus.flush_i = 1'b0;
        drive_fetch("flush_beats_update", 32'hFE00_0EE3, 32'h100, 1'b1, 1'b1, 1'b0, 32'hFC);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
    endtask

    task automatic test_jumps_compressed();
        res_t e, g; string nm;
        pulse_reset();
        drive_fetch("c_j_backward", 32'h0000_BFFD, 32'h200, 1'b1, 1'b1, 1'b0, 32'h1FE);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        cyc();
        drive_fetch("c_jal_backward", 32'h0000_3FFD, 32'h210, 1'b1, 1'b1, 1'b0, 32'h20E);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        do_update(32'h200, 1'b0);
        drive_fetch("jal_trained_nt", 32'h0080_006F, 32'h200, 1'b1, 1'b1, 1'b0, 32'h208);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        cyc();
        drive_fetch("c_beqz_static", 32'h0000_DC7D, 32'h302, 1'b1, 1'b1, 1'b0, 32'h300);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        do_update(32'h302, 1'b0);
        drive_fetch("c_beqz_trained_nt", 32'h0000_DC7D, 32'h302, 1'b1, 1'b0, 1'b1, 32'h300);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
    endtask

    task automatic test_reset_mid();
        res_t e, g; string nm;
        do_update(32'h100, 1'b1);
        drive_fetch("mid_reset_before", 32'h0000_0863, 32'h100, 1'b1, 1'b1, 1'b1, 32'h110);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        pulse_reset();
        drive_fetch("mid_reset_after", 32'h0000_0863, 32'h100, 1'b1, 1'b0, 1'b0, 32'h110);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
        drive_fetch("mid_reset_after_bwd", 32'hFE00_0EE3, 32'h180, 1'b1, 1'b1, 1'b0, 32'h17C);
        @(negedge clk); e = exp_q.pop_front(); nm = name_q.pop_front(); g = observed(); n_checks++;
        if (g !== e) begin n_fail++; $display("FAIL %s: taken/bht/pc got %b/%b/%h want %b/%b/%h", nm, g.taken, g.bht, g.pc, e.taken, e.bht, e.pc); end
    endtask

    initial begin
        n_checks           = 0;
        n_fail             = 0;
        rst_n              = 1'b0;
        bus.fetch_rdata_i  = '0;
        bus.fetch_pc_i     = '0;
        bus.fetch_valid_i  = 1'b0;
        bus.bht_en_i       = 1'b1;
        bus.flush_i        = 1'b0;
        bus.update_valid_i = 1'b0;
        bus.update_pc_i    = '0;
        bus.update_taken_i = 1'b0;
        cyc();
        test_reset();
        test_static();
        test_training();
        test_saturation();
        test_alias_same_cycle();
        test_flush();
        test_jumps_compressed();
        test_reset_mid();
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ibex_branch_predict_bht.md
Name: ibex_branch_predict_bht

Overview:
- Dynamic successor to the static Ibex fetch-stage predictor.
- Decodes the fetched instruction (RV32 JAL/BRANCH, RVC C.J/C.JAL/C.BEQZ/C.BNEZ) and computes target = fetch_pc_i + sign-extended immediate.
- Direction for conditional branches comes from a direct-mapped, PC-indexed branch history table (BHT) of saturating counters, trained from the ID/EX stage.
- Entries never trained fall back to static backward-taken/forward-not-taken. Jumps are always predicted taken.

Parameters:
- BhtEntries, 64, number of table entries; power of two, 2..1024.
- CounterWidth, 2, saturating counter width in bits, 1..4.
- IdxW, $clog2(BhtEntries), derived localparam, not overridable.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- fetch_rdata_i  in  32  fetched instruction; compressed instructions occupy bits [15:0]
- fetch_pc_i  in  32  PC of fetch_rdata_i
- fetch_valid_i  in  1  fetch_rdata_i/fetch_pc_i valid
- bht_en_i  in  1  1: use BHT direction for trained entries; 0: pure static prediction
- flush_i  in  1  invalidate all BHT entries (e.g. on fence.i)
- update_valid_i  in  1  resolved conditional branch this cycle
- update_pc_i  in  32  PC of the resolved branch
- update_taken_i  in  1  resolved direction
- predict_branch_taken_o  out  1  predicted taken
- predict_branch_pc_o  out  32  predicted target
- predict_from_bht_o  out  1  direction taken from BHT (trained entry, bht_en_i=1, conditional branch)

Behaviour:
- Clock clk_i. Reset rst_ni is synchronous and active-low; all state changes occur on the rising edge of clk_i.
- State per entry: valid bit v[i] and counter c[i] of CounterWidth bits. No tags; aliasing is permitted.
- Reset: all v=0, all c=0.
- Outputs are combinational from inputs and current state. With fetch_valid_i=0, predict_branch_taken_o=0 and predict_from_bht_o=0. predict_branch_pc_o is always fetch_pc_i + selected immediate.
- Decode and immediates:
  - B-type, J-type, CB and CJ immediates, each sign-extended to 32 bits.
  - Instruction types are mutually exclusive.
  - Default immediate is B-type.
  - Addition wraps modulo 2^32.
- Index: rd_idx = fetch_pc_i[IdxW:1]; wr_idx = update_pc_i[IdxW:1]. Bit 0 is ignored.
- Direction:
  - Jumps (J, CJ): always taken.
  - Conditional branch (B, CB), when bht_en_i=1 and v[rd_idx]=1: taken = c[rd_idx][CounterWidth-1]; predict_from_bht_o=1.
  - Otherwise: taken = immediate sign bit (static).
  - Non-branch instructions: taken=0.
- Update, on update_valid_i=1 at a clock edge:
  - If v[wr_idx]=0: set v=1. Counter becomes WT = 2^(CW-1) if taken, else WN = 2^(CW-1)-1.
  - If v[wr_idx]=1: saturating increment if taken (max 2^CW-1), decrement if not taken (min 0).
  - CounterWidth=1 degenerates to last-outcome.
  - Training is independent of bht_en_i.
- Same-cycle read and write to the same index: the prediction uses the pre-update value (no bypass). The new value is visible next cycle.
- flush_i=1: all v cleared next cycle; counters unchanged. flush_i and update_valid_i together: flush wins and the update is dropped.
- Reset asserted mid-operation overrides flush and update; the table returns to its reset state.
- Only one update per cycle. update_pc_i is ignored when update_valid_i=0.
- Assertion: instruction-type one-hot0 when fetch_valid_i=1. Assertions use clk_i/rst_ni.
- Table storage is flops; no SRAM. Width conversion is explicit; no implicit truncation warnings.

Test Plan:
- Untrained forward branch: after reset, fetch_pc=0x100, rdata=0x00000863 (beq +16), valid=1 -> taken=0, pc=0x110, from_bht=0. Backward branch rdata=0xFE000EE3 (beq -4) -> taken=1, pc=0xFC.
- Training: one update(pc=0x100, taken=1), then fetch 0x00000863 @0x100 -> taken=1, from_bht=1. One update(taken=0) -> taken=0 (WT->WN). Same fetch with bht_en_i=0 -> taken=0, from_bht=0.
- Saturation: three taken updates @0x100 (counter=3), then one not-taken -> counter=2, still taken=1. Four not-taken updates, then a fifth -> counter stays 0, taken=0.
- Aliasing and same-cycle rules (BhtEntries=64):
  - Training 0x100 taken affects fetch @0x180 (same index) -> taken=1.
  - Untrained entry with update and fetch at the same index in the same cycle -> static result this cycle, BHT result next cycle.
- Flush: train 0x100 with backward branch not-taken (taken=0), assert flush_i together with update_valid_i -> next cycle the backward branch predicts taken=1 (static), from_bht=0.
- Jumps and compressed instructions:
  - C.J 0xBFFD @0x200 -> taken=1, pc=0x1FE.
  - JAL 0x0080006F @0x200 -> taken=1, pc=0x208, even with the entry trained not-taken.
  - Sync reset pulse mid-sequence clears all training.
